rr_hold_arbiter: RTL and testbench
==================================

RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter HOLD_MAX, default 8, maximum consecutive grant cycles per requester; legal range 2..255.
REQ-003 Port Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Port Reset  in  1  reset; asynchronous, active-high.
REQ-005 Port r  in  N  request vector r[1:N]; r[k]=1 means requester k wants the shared resource.
REQ-006 Port done  in  1  resource signals early completion of the current grant.
REQ-007 Port g  out  N  one-hot grant vector g[1:N], registered.
REQ-008 Port gid  out  clog2(N)  zero-based index of granted requester; 0 when no grant.
REQ-009 Port busy  out  1  high whenever any g bit is high.
REQ-010 Port timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GNT, GAP.
REQ-012 A rotating pointer ptr (0..N-1) SHALL mark the highest-priority requester.
REQ-013 In IDLE or GAP with any r bit set, the block SHALL select the first set requester at or after ptr, wrapping modulo N, and enter GNT.
REQ-014 In IDLE or GAP with r all zero, the block SHALL enter IDLE.
REQ-015 g and gid SHALL reflect the selected requester from the first GNT cycle; latency from request to grant is 1 clock from IDLE.
REQ-016 In GNT, a hold counter SHALL be cleared on entry and increment each GNT cycle.
REQ-017 GNT SHALL exit to GAP on any of: r[k]=0 for granted k, done=1, or the grant has been held HOLD_MAX cycles.
REQ-018 timeout SHALL pulse in the first GAP cycle only when exit was caused solely by the hold limit (r[k]=1 and done=0).
REQ-019 When r[k] drop, done, and hold limit coincide, exit SHALL be treated as normal release; timeout stays 0.
REQ-020 On every GNT exit, ptr SHALL become (k+1) mod N, where k is the zero-based granted index.
REQ-021 GAP SHALL last exactly one cycle with g all zero (bus turnaround), then arbitrate per REQ-013/014.
REQ-022 Requests arriving or dropping for non-granted requesters during GNT SHALL not affect the current grant.
REQ-023 At most one g bit SHALL ever be high; busy SHALL equal OR of g.

Reset
REQ-024 Reset=1 SHALL immediately force state IDLE, ptr=0, hold counter=0, g=0, gid=0, busy=0, timeout=0, independent of Clock.
REQ-025 Reset asserted mid-grant SHALL drop g within the same cycle; the first grant after release SHALL follow REQ-013 with ptr=0.

Structure
REQ-026 A shared package arb_pkg SHALL hold the state type (IDLE, GNT, GAP) and default constants for N and HOLD_MAX.
REQ-027 Rotating-priority selection SHALL be a combinational sub-module rr_pick (inputs r, ptr; outputs one-hot select, index, any).
REQ-028 Target size is 120-400 lines of RTL including rr_pick.

Verification
REQ-029 Reset then r=0001 (r[1]=1) held: g=0001 one cycle later, gid=0; g drops after 8 cycles, timeout=1 in the GAP cycle, then regranted to requester 1 (only requester).
REQ-030 r=1111 held, done=0: grants rotate 1,2,3,4,1 with 8 GNT cycles each, one GAP cycle between, timeout pulses each rotation.
REQ-031 Requester 3 granted, done=1 on 3rd GNT cycle: GAP next cycle, timeout=0, ptr=3 (requester 4 next).
REQ-032 Requester 2 granted, r[2] falls on the same cycle done=1 and hold count reaches 8: GAP, timeout=0.
REQ-033 Reset asserted mid-grant to requester 4 between clock edges: g=0 before next edge; after release with r=1111 first grant goes to requester 1.
REQ-034 Random r/done for 10000 cycles: g always one-hot or zero, no GNT exceeds HOLD_MAX cycles, no requester held high starves beyond (N-1)*(HOLD_MAX+1) cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin hold-limited arbiter.
package arb_pkg;

    localparam int N_DEF        = 4;
    localparam int HOLD_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  r,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic found;
    int   j;

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            if (!found) begin
                j = (int'(ptr) + i) % N;
                if (r[j]) begin
                    found  = 1'b1;
                    sel[j] = 1'b1;
                    idx    = IW'(j);
                end
            end
        end
    end

    assign any = |r;

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a per-grant hold limit and a one-cycle turnaround gap.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N-1:0]         r,
    input  logic                 done,
    output logic [N-1:0]         g,
    output logic [$clog2(N)-1:0] gid,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IW = $clog2(N);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [7:0]    hold;

    logic [N-1:0]  psel;
    logic [IW-1:0] pidx;
    logic          pany;
    logic          rel;
    logic          lim;
    logic [IW-1:0] nptr;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .r   (r),
        .ptr (ptr),
        .sel (psel),
        .idx (pidx),
        .any (pany)
    );

    // hold counts completed GNT cycles, so the HOLD_MAX-th cycle sees HOLD_MAX-1
    assign rel  = !r[gid] || done;
    assign lim  = (hold == 8'(HOLD_MAX - 1));
    assign nptr = (gid == IW'(N - 1)) ? '0 : gid + 1'b1;
    assign busy = |g;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ptr     <= '0;
            hold    <= '0;
            g       <= '0;
            gid     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE, GAP: begin
                    hold <= '0;
                    if (pany) begin
                        state <= GNT;
                        g     <= psel;
                        gid   <= pidx;
                    end else begin
                        state <= IDLE;
                        g     <= '0;
                        gid   <= '0;
                    end
                end
                GNT: begin
                    if (rel || lim) begin
                        state   <= GAP;
                        g       <= '0;
                        gid     <= '0;
                        hold    <= '0;
                        ptr     <= nptr;
                        // a normal release wins over a coincident hold limit
                        timeout <= lim && !rel;
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    g     <= '0;
                    gid   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed and random checks for rr_hold_arbiter with N=4, HOLD_MAX=8.
module tb_rr_hold_arbiter;

    localparam int N  = 4;
    localparam int HM = 8;

    logic         Clock;
    logic         Reset;
    logic [N-1:0] r;
    logic         done;
    logic [N-1:0] g;
    logic [1:0]   gid;
    logic         busy;
    logic         timeout;

    int tests;
    int fails;

    rr_hold_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .r       (r),
        .done    (done),
        .g       (g),
        .gid     (gid),
        .busy    (busy),
        .timeout (timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        r     = '0;
        done  = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        r     = 4'b1111;
        done  = 1'b0;
        #22;
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL reset_g: got %b expected 0000", g); end
        tests++; if (gid !== 2'd0) begin fails++; $display("FAIL reset_gid: got %0d expected 0", gid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_single();
        do_reset();
        r = 4'b0001;
        step();
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL single_first_g: got %b expected 0001", g); end
        tests++; if (gid !== 2'd0) begin fails++; $display("FAIL single_first_gid: got %0d expected 0", gid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
        for (int c = 1; c < HM; c++) begin
            step();
            tests++; if (g !== 4'b0001) begin fails++; $display("FAIL single_hold_c%0d: got %b expected 0001", c, g); end
        end
        step();
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL single_gap_g: got %b expected 0000", g); end
        tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL single_gap_timeout: got %b expected 1", timeout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_gap_busy: got %b expected 0", busy); end
        step();
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL single_regrant_g: got %b expected 0001", g); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL single_regrant_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_rotate();
        logic [N-1:0] eg;
        do_reset();
        r = 4'b1111;
        step();
        for (int gi = 0; gi < 5; gi++) begin
            eg = 4'b0001 << (gi % N);
            for (int c = 0; c < HM; c++) begin
                tests++; if (g !== eg) begin fails++; $display("FAIL rotate_g%0d_c%0d: got %b expected %b", gi, c, g, eg); end
                tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rotate_to%0d_c%0d: got %b expected 0", gi, c, timeout); end
                step();
            end
            tests++; if (g !== 4'b0000) begin fails++; $display("FAIL rotate_gap%0d: got %b expected 0000", gi, g); end
            tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL rotate_gap_to%0d: got %b expected 1", gi, timeout); end
            step();
        end
    endtask

    task automatic test_done_early();
        do_reset();
        r = 4'b0100;
        step();
        tests++; if (gid !== 2'd2) begin fails++; $display("FAIL done_gid: got %0d expected 2", gid); end
        r = 4'b1111;
        step();
        step();
        tests++; if (g !== 4'b0100) begin fails++; $display("FAIL done_third_g: got %b expected 0100", g); end
        done = 1'b1;
        step();
        done = 1'b0;
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL done_gap_g: got %b expected 0000", g); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL done_gap_timeout: got %b expected 0", timeout); end
        step();
        tests++; if (g !== 4'b1000) begin fails++; $display("FAIL done_next_g: got %b expected 1000", g); end
        tests++; if (gid !== 2'd3) begin fails++; $display("FAIL done_next_gid: got %0d expected 3", gid); end
    endtask

    task automatic test_coincide();
        do_reset();
        r = 4'b0010;
        step();
        repeat (HM - 1) step();
        tests++; if (g !== 4'b0010) begin fails++; $display("FAIL coin_last_g: got %b expected 0010", g); end
        r    = 4'b0000;
        done = 1'b1;
        step();
        done = 1'b0;
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL coin_gap_g: got %b expected 0000", g); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL coin_gap_timeout: got %b expected 0", timeout); end
        step();
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL coin_idle_g: got %b expected 0000", g); end
        // done alone at the hold limit is still a normal release
        r = 4'b0001;
        step();
        repeat (HM - 1) step();
        done = 1'b1;
        step();
        done = 1'b0;
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL limdone_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_drop();
        do_reset();
        r = 4'b0011;
        step();
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL drop_first_g: got %b expected 0001", g); end
        r = 4'b0001;
        step();
        r = 4'b1101;
        step();
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL drop_others_g: got %b expected 0001", g); end
        r = 4'b1100;
        step();
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL drop_gap_g: got %b expected 0000", g); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL drop_gap_timeout: got %b expected 0", timeout); end
        step();
        tests++; if (g !== 4'b0100) begin fails++; $display("FAIL drop_next_g: got %b expected 0100", g); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        r = 4'b1000;
        step();
        step();
        tests++; if (g !== 4'b1000) begin fails++; $display("FAIL rmid_pre_g: got %b expected 1000", g); end
        #2;
        Reset = 1'b1;
        #1;
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL rmid_async_g: got %b expected 0000", g); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_async_busy: got %b expected 0", busy); end
        r = 4'b1111;
        step();
        Reset = 1'b0;
        step();
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL rmid_after_g: got %b expected 0001", g); end
    endtask

    task automatic test_random();
        int           w [N];
        int           run;
        logic [N-1:0] gprev;
        logic [N-1:0] rr;
        do_reset();
        rr    = '0;
        run   = 0;
        gprev = '0;
        for (int k = 0; k < N; k++) w[k] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 15) == 0) rr[k] = ~rr[k];
            r    = rr;
            done = ($urandom_range(0, 19) == 0);
            step();
            tests++; if (!$onehot0(g)) begin fails++; $display("FAIL rand_onehot @%0d: got %b expected one-hot or zero", cyc, g); end
            tests++; if (busy !== (g != '0)) begin fails++; $display("FAIL rand_busy @%0d: got %b expected %b", cyc, busy, (g != '0)); end
            run = (g == '0) ? 0 : ((g == gprev) ? run + 1 : 1);
            tests++; if (run > HM) begin fails++; $display("FAIL rand_hold @%0d: got %0d cycles expected <= %0d", cyc, run, HM); end
            for (int k = 0; k < N; k++) begin
                w[k] = (!rr[k] || g[k] || gprev[k]) ? 0 : w[k] + 1;
                if (w[k] > (N - 1) * (HM + 1)) begin
                    fails++;
                    $display("FAIL rand_starve%0d @%0d: got %0d cycles expected <= %0d", k, cyc, w[k], (N - 1) * (HM + 1));
                    w[k] = 0;
                end
            end
            tests++;
            gprev = g;
        end
        r    = '0;
        done = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_rotate();
        test_done_early();
        test_coincide();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
